enc_8_3_drain: RTL

Sequential 8-to-3 encoder. It is the inverse of the team's 3-to-8 decoder: one-hot 8'b1<<k encodes back to k. The block latches a multi-hot 8-bit request vector and drains it as a stream of 3-bit indices, one per accepted transfer, in priority order. It sits between request/flag collectors and consumers that need one index at a time, under a valid/ready handshake on both sides.

---
 rtl/enc_8_3_drain.sv | 114 +++++++++++
 1 files changed

// File: rtl/enc_8_3_drain.sv
// Sequential 8-to-3 encoder: latches a multi-hot request vector and drains it
// as a stream of 3-bit indices in priority order, one per accepted transfer.
module enc_8_3_drain #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] a,
  output logic       in_ready,
  output logic [2:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       last,
  output logic [3:0] cnt
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [7:0] pend_reg;
  logic [2:0] y_reg;
  logic       last_reg;
  logic [3:0] cnt_reg;
  logic [7:0] pend_clr;
  logic       load;
  logic       xfer;

  // Index of the bit that goes out first: highest or lowest set bit.
  function automatic logic [2:0] prio(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++)
        if (v[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++)
      n = n + {3'd0, v[i]};
    return n;
  endfunction

  // Pending vector with the currently presented index removed.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_clr
      assign pend_clr[gi] = pend_reg[gi] & (y_reg != 3'(gi));
    end
  endgenerate

  assign load = (state_reg == IDLE) && en && (a != 8'd0);
  assign xfer = (state_reg == DRAIN) && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state: leave IDLE on a nonzero load, return after the final transfer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = DRAIN;
      DRAIN:   if (xfer && (pend_clr == 8'd0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state flop.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DRAIN);
  end

  // Datapath: load the vector, then step to the next index on each transfer.
  // y is left untouched on the final transfer so it holds its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_reg <= 8'd0;
      y_reg    <= 3'd0;
      last_reg <= 1'b0;
      cnt_reg  <= 4'd0;
    end else if (load) begin
      pend_reg <= a;
      y_reg    <= prio(a);
      last_reg <= (popcount(a) == 4'd1);
      cnt_reg  <= popcount(a);
    end else if (xfer) begin
      if (pend_clr != 8'd0) begin
        pend_reg <= pend_clr;
        y_reg    <= prio(pend_clr);
        last_reg <= (popcount(pend_clr) == 4'd1);
        cnt_reg  <= cnt_reg - 4'd1;
      end else begin
        pend_reg <= 8'd0;
        last_reg <= 1'b0;
        cnt_reg  <= 4'd0;
      end
    end
  end

  assign y    = y_reg;
  assign last = last_reg;
  assign cnt  = cnt_reg;

endmodule
